// File: rtl/capture_fifo_mm_slave.sv
// Avalon-MM slave exposing a capture FIFO plus CTRL/STATUS/DROP_COUNT registers.
// Define CAPTURE_TIMESTAMP_EN to map a free-running cycle counter at word address 4.
module capture_fifo_mm_slave #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 16,
    parameter int EMPTY_TIMEOUT = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_WIDTH-1:0]   writedata,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic [1:0]              response,
    output logic                    waitrequest,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic [15:0]             fifo_level,
    output logic [1:0]              dbg_state_o
);
    localparam int          AW          = $clog2(FIFO_DEPTH);
    localparam logic [15:0] DEPTH_L     = 16'(FIFO_DEPTH);
    localparam logic [15:0] TO_LAST     = 16'(EMPTY_TIMEOUT - 1);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACK = 2'd1, S_WAIT = 2'd2} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] readdata_q, readdata_d;
    logic [1:0]            response_q, response_d;
    logic [15:0]           wait_cnt_q, wait_cnt_d;
    logic                  enable_q, enable_d;
    logic                  clear_q, clear_d;
    logic                  overflow_q;
    logic [31:0]           drop_q;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [15:0]           count_q;
    logic                  fifo_empty, fifo_full, pop, w1c;
    logic                  accept_push, drop_push, addr_hi_nz, decode_ok;
    logic [2:0]            reg_sel;
    logic [31:0]           status_word;

    assign reg_sel     = address[2:0];
    assign addr_hi_nz  = |(address >> 3);
    assign fifo_empty  = (count_q == 16'd0);
    assign fifo_full   = (count_q == DEPTH_L);
    assign status_word = {13'd0, fifo_full, fifo_empty, overflow_q, count_q};

`ifdef CAPTURE_TIMESTAMP_EN
    logic [31:0] ts_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) ts_q <= '0;
        else       ts_q <= ts_q + 32'd1;
    end
    assign decode_ok = !addr_hi_nz && (reg_sel <= 3'd4);
`else
    assign decode_ok = !addr_hi_nz && (reg_sel <= 3'd3);
`endif

    // A pop frees a slot in the same cycle, so a push into a full FIFO is kept then.
    assign accept_push = in_valid && enable_q && !clear_q && (!fifo_full || pop);
    assign drop_push   = in_valid && enable_q && !clear_q && fifo_full && !pop;

    always_comb begin
        state_d    = state_q;
        readdata_d = readdata_q;
        response_d = response_q;
        wait_cnt_d = wait_cnt_q;
        enable_d   = enable_q;
        clear_d    = 1'b0;
        pop        = 1'b0;
        w1c        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (read || write) begin
                    state_d    = S_ACK;
                    readdata_d = '0;
                    response_d = RESP_OKAY;
                    if (!decode_ok) begin
                        response_d = RESP_DECERR;
                    end else if (write) begin
                        case (reg_sel)
                            3'd0: if (byteenable[0]) begin
                                enable_d = writedata[0];
                                clear_d  = writedata[1];
                            end
                            3'd1: w1c = byteenable[2] && writedata[16];
                            default: ;
                        endcase
                    end else begin
                        case (reg_sel)
                            3'd0: readdata_d = {{(DATA_WIDTH-1){1'b0}}, enable_q};
                            3'd1: readdata_d = status_word;
                            3'd2: begin
                                if (!fifo_empty) begin
                                    pop        = 1'b1;
                                    readdata_d = mem_q[rd_ptr_q];
                                end else if (EMPTY_TIMEOUT == 1) begin
                                    response_d = RESP_SLVERR;
                                end else begin
                                    state_d    = S_WAIT;
                                    wait_cnt_d = 16'd1;
                                end
                            end
                            3'd3: readdata_d = drop_q;
`ifdef CAPTURE_TIMESTAMP_EN
                            3'd4: readdata_d = ts_q;
`endif
                            default: ;
                        endcase
                    end
                end
            end
            S_ACK: state_d = S_IDLE;
            S_WAIT: begin
                // wait_cnt counts every stalled cycle including the initial wait state
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    readdata_d = mem_q[rd_ptr_q];
                    response_d = RESP_OKAY;
                    state_d    = S_ACK;
                end else if (wait_cnt_q == TO_LAST) begin
                    readdata_d = '0;
                    response_d = RESP_SLVERR;
                    state_d    = S_ACK;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            readdata_q <= '0;
            response_q <= RESP_OKAY;
            wait_cnt_q <= '0;
            enable_q   <= 1'b0;
            clear_q    <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            readdata_q <= readdata_d;
            response_q <= response_d;
            wait_cnt_q <= wait_cnt_d;
            enable_q   <= enable_d;
            clear_q    <= clear_d;
            if (clear_q) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                count_q    <= '0;
                drop_q     <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (accept_push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)         rd_ptr_q <= rd_ptr_q + AW'(1);
                count_q <= count_q + {15'd0, accept_push} - {15'd0, pop};
                if (drop_push) begin
                    overflow_q <= 1'b1;
                    if (drop_q != 32'hFFFF_FFFF) drop_q <= drop_q + 32'd1;
                end else if (w1c) begin
                    overflow_q <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept_push) mem_q[wr_ptr_q] <= in_data;
    end

    assign readdata    = readdata_q;
    assign response    = response_q;
    assign waitrequest = (state_q != S_ACK);
    assign fifo_level  = count_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_capture_fifo_mm_slave.sv
// Bench for capture_fifo_mm_slave: register vector table, directed corner sequences,
// and randomized traffic checked against a queue-based model of the FIFO and registers.
module tb_capture_fifo_mm_slave;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 64;

    logic        clk, rst;
    logic [31:0] address, writedata, in_data;
    logic [3:0]  byteenable;
    logic        read, write, in_valid;
    logic [31:0] readdata;
    logic [1:0]  response, dbg_state;
    logic        waitrequest;
    logic [15:0] fifo_level;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int req_cyc = 0;

    // model state
    logic [31:0] exp_q[$];
    bit          enable_m;
    bit          ovf_m;
    logic [31:0] drop_m;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic [1:0]  exp_resp;
    } vec_t;
    vec_t vecs[19];

    capture_fifo_mm_slave dut (
        .clock(clk), .reset(rst), .address(address), .byteenable(byteenable),
        .read(read), .write(write), .writedata(writedata), .readdata(readdata),
        .response(response), .waitrequest(waitrequest), .in_valid(in_valid),
        .in_data(in_data), .fifo_level(fifo_level), .dbg_state_o(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input int limit,
                       output logic [31:0] rdata, output logic [1:0] resp, output int waits);
        @(negedge clk);
        read = rd; write = wr; address = addr; writedata = wd; byteenable = be;
        rdata = 32'hDEAD_BEEF; resp = 2'b01;
        @(posedge clk);
        req_cyc = cyc;
        #1;
        waits = 1;
        while (waitrequest && waits < limit) begin
            @(posedge clk); #1;
            waits++;
        end
        if (!waitrequest) begin
            rdata = readdata;
            resp  = response;
        end
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] d);
        @(negedge clk);
        in_valid = 1'b1; in_data = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    function automatic void model_push(input logic [31:0] d);
        if (enable_m) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(d);
            else begin
                ovf_m = 1'b1;
                if (drop_m != 32'hFFFF_FFFF) drop_m = drop_m + 1;
            end
        end
    endfunction

    function automatic logic [31:0] model_status();
        int n = exp_q.size();
        return {13'd0, (n == DEPTH), (n == 0), ovf_m, 16'(n)};
    endfunction

    task automatic model_reset();
        exp_q.delete(); enable_m = 1'b0; ovf_m = 1'b0; drop_m = '0;
    endtask

    logic [31:0] rd_v, rd_v2;
    logic [1:0]  rs_v, rs_v2;
    int          w_v, w_v2;

    initial begin
        rst = 1'b1; read = 0; write = 0; address = 0; writedata = 0; byteenable = 0;
        in_valid = 0; in_data = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_waitreq", {31'd0, waitrequest}, 32'd1);
        check("reset_readdata", readdata, 32'd0);
        check("reset_response", {30'd0, response}, 32'd0);
        check("reset_level", {16'd0, fifo_level}, 32'd0);
        @(negedge clk); rst = 1'b0;

        // register vector table: {rd, wr, addr, wdata, be, exp readdata, exp response}
        vecs[0]  = '{0, 1, 32'd0,     32'h1,    4'hF, 32'h0,       2'b00};
        vecs[1]  = '{1, 0, 32'd0,     32'h0,    4'hF, 32'h1,       2'b00};
        vecs[2]  = '{1, 0, 32'd1,     32'h0,    4'hF, 32'h0002_0000, 2'b00};
        vecs[3]  = '{1, 0, 32'd3,     32'h0,    4'hF, 32'h0,       2'b00};
        vecs[4]  = '{1, 0, 32'd7,     32'h0,    4'hF, 32'h0,       2'b11};
        vecs[5]  = '{1, 0, 32'h100,   32'h0,    4'hF, 32'h0,       2'b11};
        vecs[6]  = '{0, 1, 32'h100,   32'h0,    4'hF, 32'h0,       2'b11};
        vecs[7]  = '{1, 0, 32'd0,     32'h0,    4'hF, 32'h1,       2'b00};
        vecs[8]  = '{0, 1, 32'd0,     32'h0,    4'h0, 32'h0,       2'b00};
        vecs[9]  = '{1, 0, 32'd0,     32'h0,    4'hF, 32'h1,       2'b00};
        vecs[10] = '{0, 1, 32'd3,     32'h1234, 4'hF, 32'h0,       2'b00};
        vecs[11] = '{1, 0, 32'd3,     32'h0,    4'hF, 32'h0,       2'b00};
        vecs[12] = '{1, 0, 32'd5,     32'h0,    4'hF, 32'h0,       2'b11};
        vecs[13] = '{1, 1, 32'd0,     32'h0,    4'hF, 32'h0,       2'b00};
        vecs[14] = '{1, 0, 32'd0,     32'h0,    4'hF, 32'h0,       2'b00};
        vecs[15] = '{0, 1, 32'd0,     32'h3,    4'hF, 32'h0,       2'b00};
        vecs[16] = '{1, 0, 32'd0,     32'h0,    4'hF, 32'h1,       2'b00};
        vecs[17] = '{0, 1, 32'd8,     32'h1,    4'hF, 32'h0,       2'b11};
        vecs[18] = '{1, 0, 32'd6,     32'h0,    4'hF, 32'h0,       2'b11};
        for (int i = 0; i < 19; i++) begin
            bus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].be, 10, rd_v, rs_v, w_v);
            check($sformatf("vec%0d_resp", i), {30'd0, rs_v}, {30'd0, vecs[i].exp_resp});
            check($sformatf("vec%0d_waits", i), w_v, 32'd1);
            if (vecs[i].rd && !vecs[i].wr)
                check($sformatf("vec%0d_rdata", i), rd_v, vecs[i].exp_rd);
        end
        enable_m = 1'b1;

        // in-order pop of four words
        for (int i = 0; i < 4; i++) begin push_word(32'hA0 + i); model_push(32'hA0 + i); end
        for (int i = 0; i < 4; i++) begin
            bus(1, 0, 32'd2, 0, 4'hF, 10, rd_v, rs_v, w_v);
            check("order_data", rd_v, exp_q.pop_front());
            check("order_resp", {30'd0, rs_v}, 32'd0);
        end
        bus(1, 0, 32'd1, 0, 4'hF, 10, rd_v, rs_v, w_v);
        check("status_empty", rd_v, 32'h0002_0000);

        // overflow: 20 pushes into a 16-deep FIFO
        for (int i = 0; i < 20; i++) begin push_word(32'h100 + i); model_push(32'h100 + i); end
        check("ovf_level_port", {16'd0, fifo_level}, 32'd16);
        bus(1, 0, 32'd1, 0, 4'hF, 10, rd_v, rs_v, w_v);
        check("ovf_status", rd_v, 32'h0005_0010);
        bus(1, 0, 32'd3, 0, 4'hF, 10, rd_v, rs_v, w_v);
        check("ovf_drop", rd_v, 32'd4);
        bus(0, 1, 32'd1, 32'h0001_0000, 4'hF, 10, rd_v, rs_v, w_v);
        bus(1, 0, 32'd1, 0, 4'hF, 10, rd_v, rs_v, w_v);
        check("w1c_status", rd_v, 32'h0004_0010);
        bus(0, 1, 32'd0, 32'h3, 4'hF, 10, rd_v, rs_v, w_v);
        check("clear_level_port", {16'd0, fifo_level}, 32'd0);
        bus(1, 0, 32'd1, 0, 4'hF, 10, rd_v, rs_v, w_v);
        check("clear_status", rd_v, 32'h0002_0000);
        bus(1, 0, 32'd3, 0, 4'hF, 10, rd_v, rs_v, w_v);
        check("clear_drop", rd_v, 32'd0);
        model_reset(); enable_m = 1'b1;

        // full FIFO: push and pop on the same edge
        for (int i = 0; i < DEPTH; i++) begin push_word(32'h200 + i); model_push(32'h200 + i); end
        fork
            bus(1, 0, 32'd2, 0, 4'hF, 10, rd_v, rs_v, w_v);
            begin
                @(negedge clk); in_valid = 1'b1; in_data = 32'h2FF;
                @(negedge clk); in_valid = 1'b0;
            end
        join
        check("fullpop_data", rd_v, exp_q.pop_front());
        exp_q.push_back(32'h2FF);
        check("fullpop_level", {16'd0, fifo_level}, 32'd16);
        bus(1, 0, 32'd1, 0, 4'hF, 10, rd_v, rs_v, w_v);
        check("fullpop_status", rd_v, 32'h0004_0010);
        bus(1, 0, 32'd3, 0, 4'hF, 10, rd_v, rs_v, w_v);
        check("fullpop_drop", rd_v, 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            bus(1, 0, 32'd2, 0, 4'hF, 10, rd_v, rs_v, w_v);
            check("drain_data", rd_v, exp_q.pop_front());
        end

        // empty-FIFO DATA read: timeout, then a late push
        bus(1, 0, 32'd2, 0, 4'hF, 200, rd_v, rs_v, w_v);
        check("timeout_waits", w_v, TIMEOUT);
        check("timeout_rdata", rd_v, 32'd0);
        check("timeout_resp", {30'd0, rs_v}, 32'h2);
        fork
            bus(1, 0, 32'd2, 0, 4'hF, 200, rd_v, rs_v, w_v);
            begin repeat (10) @(posedge clk); push_word(32'h55); end
        join
        check("late_rdata", rd_v, 32'h55);
        check("late_resp", {30'd0, rs_v}, 32'd0);
        check("late_fast", {31'd0, (w_v < TIMEOUT)}, 32'd1);
        check("late_level", {16'd0, fifo_level}, 32'd0);

`ifdef CAPTURE_TIMESTAMP_EN
        bus(1, 0, 32'd4, 0, 4'hF, 10, rd_v, rs_v, w_v);
        w_v = req_cyc;
        repeat ($urandom_range(3, 40)) @(posedge clk);
        bus(1, 0, 32'd4, 0, 4'hF, 10, rd_v2, rs_v2, w_v2);
        check("ts_resp", {30'd0, rs_v2}, 32'd0);
        check("ts_delta", rd_v2 - rd_v, 32'(req_cyc - w_v));
`else
        bus(1, 0, 32'd4, 0, 4'hF, 10, rd_v, rs_v, w_v);
        check("addr4_resp", {30'd0, rs_v}, 32'h3);
        check("addr4_rdata", rd_v, 32'd0);
`endif

        // reset while a DATA read is stalled on an empty FIFO
        @(negedge clk); read = 1'b1; address = 32'd2;
        w_v = 1;
        repeat (20) begin @(posedge clk); #1; if (!waitrequest) w_v = 0; end
        check("midwait_held", w_v, 32'd1);
        @(negedge clk); rst = 1'b1; #1;
        check("midwait_rst_waitreq", {31'd0, waitrequest}, 32'd1);
        check("midwait_rst_level", {16'd0, fifo_level}, 32'd0);
        read = 1'b0;
        @(negedge clk); rst = 1'b0;
        model_reset();
        bus(1, 0, 32'd0, 0, 4'hF, 10, rd_v, rs_v, w_v);
        check("post_rst_ctrl", rd_v, 32'd0);
        check("post_rst_waits", w_v, 32'd1);
        bus(0, 1, 32'd0, 32'h1, 4'hF, 10, rd_v, rs_v, w_v);
        enable_m = 1'b1;

        // randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                int len;
                len = $urandom_range(1, 8);
                for (int k = 0; k < len; k++) begin
                    logic [31:0] d;
                    d = $urandom;
                    push_word(d); model_push(d);
                end
            end else if (op <= 5 && exp_q.size() > 0) begin
                bus(1, 0, 32'd2, 0, 4'hF, 10, rd_v, rs_v, w_v);
                check("rnd_data", rd_v, exp_q.pop_front());
                check("rnd_data_resp", {30'd0, rs_v}, 32'd0);
            end else if (op <= 6) begin
                bus(1, 0, 32'd1, 0, 4'hF, 10, rd_v, rs_v, w_v);
                check("rnd_status", rd_v, model_status());
            end else if (op == 7) begin
                bus(1, 0, 32'd3, 0, 4'hF, 10, rd_v, rs_v, w_v);
                check("rnd_drop", rd_v, drop_m);
            end else if (op == 8) begin
                bit en, clr;
                en  = ($urandom_range(0, 3) != 0);
                clr = ($urandom_range(0, 7) == 0);
                bus(0, 1, 32'd0, {30'd0, clr, en}, 4'hF, 10, rd_v, rs_v, w_v);
                enable_m = en;
                if (clr) begin exp_q.delete(); ovf_m = 1'b0; drop_m = '0; end
            end else begin
                bit w1;
                w1 = $urandom_range(0, 1);
                bus(0, 1, 32'd1, {15'd0, w1, 16'd0}, 4'hF, 10, rd_v, rs_v, w_v);
                if (w1) ovf_m = 1'b0;
            end
            check("rnd_level", {16'd0, fifo_level}, 32'(exp_q.size()));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/capture_fifo_mm_slave.md
Name: capture_fifo_mm_slave

Overview:
Avalon-MM slave that buffers captured words from the filter datapath in a FIFO and exposes them, plus control/status registers, to the host-side Avalon-MM master. Sits directly downstream of the capture datapath and directly upstream of the host bus master. The master pops data by reading the DATA register. Waitrequest-based handshake only; no readdatavalid or bursts.

Parameters:
ADDR_WIDTH, 32, width of address; word-addressed.
DATA_WIDTH, 32, width of readdata/writedata/in_data; must be 32.
FIFO_DEPTH, 16, FIFO entries; power of two, 2..32768.
EMPTY_TIMEOUT, 64, cycles a DATA read waits on an empty FIFO before erroring; 1..65535.

Ports:
clock  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-high reset.
address  in  ADDR_WIDTH  word address.
byteenable  in  DATA_WIDTH/8  write byte lanes.
read  in  1  read request.
write  in  1  write request.
writedata  in  DATA_WIDTH  write data.
readdata  out  DATA_WIDTH  read data, valid while waitrequest=0 and read=1.
response  out  2  00 OKAY, 10 SLAVEERROR, 11 DECODEERROR.
waitrequest  out  1  stall; low for exactly one cycle per transaction.
in_valid  in  1  capture word valid.
in_data  in  DATA_WIDTH  capture word.
fifo_level  out  16  current occupancy.

Behaviour:
- Reset (asynchronous, active-high): waitrequest=1, readdata=0, response=00, FIFO empty, fifo_level=0, enable=0, overflow=0, drop count=0, FSM in IDLE. Reset during a transaction aborts it with no acknowledge.
- Register map (word addresses; any nonzero bits above [2:0] cause a decode error): 0 CTRL RW: bit0 enable; bit1 clear, write-only, self-clearing, reads 0. 1 STATUS RO: [15:0] level, [16] overflow (W1C), [17] empty, [18] full. 2 DATA RO: read pops the FIFO. 3 DROP_COUNT RO: 32-bit, saturating.
- CTRL writes honour byteenable[0] only. Writes to RO registers are ignored with response OKAY, except the STATUS overflow W1C bit.
- FSM IDLE: waitrequest=1. If read or write is sampled at an edge, transition as follows:
  - DATA read with FIFO empty: go to WAIT.
  - Any other request: go to ACK.
- A request with both read and write set is treated as a write.
- ACK: waitrequest=0 for one cycle, with registered readdata/response, then return to IDLE. Register access latency is one wait state.
- WAIT: count cycles.
  - FIFO becomes non-empty: pop, go to ACK with the popped word and OKAY.
  - Count reaches EMPTY_TIMEOUT: go to ACK with readdata=0 and response=10.
- A DATA pop occurs exactly once per acknowledged read. The word popped is the oldest (FIFO order).
- Unmapped address: readdata=0, response=11; a write has no effect.
- Push: in_valid=1 while enable=1.
  - FIFO not full: store the word.
  - FIFO full with no pop in the same cycle: drop the word, set overflow, increment DROP_COUNT (saturates at 0xFFFFFFFF).
  - FIFO full with a pop in the same cycle: accept the push; level is unchanged.
- in_valid while enable=0: the word is discarded and not counted.
- Clear: flushes the FIFO, zeroes DROP_COUNT, clears overflow. Takes effect on the cycle after the write is acknowledged. A push in that same cycle is discarded uncounted.
- Overflow W1C and a new drop in the same cycle: overflow stays set.
- fifo_level is registered and updates the cycle after each push/pop. The FIFO pointers wrap modulo FIFO_DEPTH.

Optional Feature:
CAPTURE_TIMESTAMP_EN.
- Defined: word address 4 is TIMESTAMP RO, a free-running 32-bit cycle counter (reset 0, wraps at 2^32). The value returned is the one sampled at the request edge.
- Undefined: address 4 is unmapped (readdata=0, response=11), and no counter logic is generated.

Test Plan:
- Reset, write CTRL=0x1, read CTRL -> readdata 0x1, response 00, waitrequest low exactly one cycle after request.
- Push 0xA0..0xA3 with enable=1, read DATA 4 times -> 0xA0,0xA1,0xA2,0xA3 in order; STATUS then reads 0x00020000 (empty, level 0).
- FIFO_DEPTH=16: push 20 words without reads -> STATUS reads 0x00050010 (level 16, overflow, full), DROP_COUNT=4; write STATUS=0x00010000 -> overflow clears; CTRL=0x3 -> level 0, DROP_COUNT=0.
- DATA read on empty FIFO with no push -> waitrequest high for EMPTY_TIMEOUT (64) cycles, then readdata 0, response 10. Repeat with a push of 0x55 at cycle 10 -> readdata 0x55, response 00.
- Read address 7 and address 0x100 -> response 11, readdata 0. With CAPTURE_TIMESTAMP_EN, two reads of address 4 spaced N cycles apart differ by N (wrap-aware).
- Full FIFO with simultaneous push and DATA pop -> push accepted, level stays 16, DROP_COUNT unchanged; assert reset mid-WAIT -> waitrequest=1, level 0, next read serviced normally.
